// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned SERIAL_ADDER_WIDTH = 8;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one
// fulladder cell with the carry registered between bits.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned   CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_cout;

  fulladder u_fulladder (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)     state_d = RUN;
      RUN:     if (cnt == LAST)  state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Shifting sum_sh right and OR-ing s into the MSB keeps WIDTH = 1 legal
  // without a separate slice-free branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_sh <= (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sh;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH = 8 and WIDTH = 1.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
  logic [0:0] a1, b1, sum1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [8:0]  exp_q[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
  );

  task automatic wait_out8(output int lat);
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Drive one operation (accepted on the next edge) and wait for out_valid.
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                     output int lat, output logic [8:0] got);
    a8 = ia; b8 = ib; cin8 = ic; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(1));
    wait_out8(lat);
    got = {cout8, sum8};
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #2;
    n_checks++;
    if ({in_ready8, out_valid8, cout8, sum8} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_w8: in_ready=%b out_valid=%b cout=%b sum=%h, required 1 0 0 00",
               in_ready8, out_valid8, cout8, sum8);
    end
    n_checks++;
    if ({in_ready1, out_valid1, cout1, sum1} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_w1: in_ready=%b out_valid=%b cout=%b sum=%b, required 1 0 0 0",
               in_ready1, out_valid1, cout1, sum1);
    end
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_basic;
    int lat;
    logic [8:0] got, exp;
    out_ready8 = 1'b1;
    exp_q.push_back(9'h010);
    op8(8'h0F, 8'h01, 1'b0, lat, got);
    n_checks++;
    if (lat != 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges, required 8", lat);
    end
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL basic_sum: got {cout,sum}=%h, required %h", got, exp);
    end
    n_checks++;
    if (in_ready8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ready_in_done: in_ready=%b, required 0", in_ready8);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_overflow;
    int lat;
    logic [8:0] got, exp;
    out_ready8 = 1'b1;
    exp_q.push_back(9'h100);
    op8(8'hFF, 8'h01, 1'b0, lat, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || lat != 8) begin
      n_fail++;
      $display("FAIL overflow_ff_01: got %h lat %0d, required %h lat 8", got, lat, exp);
    end
    @(posedge clk); #1;
    exp_q.push_back(9'h1FF);
    op8(8'hFF, 8'hFF, 1'b1, lat, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || lat != 8) begin
      n_fail++;
      $display("FAIL overflow_ff_ff_c: got %h lat %0d, required %h lat 8", got, lat, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [8:0] got, exp;
    out_ready8 = 1'b0;
    exp_q.push_back(9'h046);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h55; b8 = 8'h66; cin8 = 1'b1;   // in_valid stays high throughout
    wait_out8(lat);
    exp = exp_q.pop_front();
    n_checks++;
    if ({cout8, sum8} !== exp || lat != 8) begin
      n_fail++;
      $display("FAIL bp_first: got %h lat %0d, required %h lat 8", {cout8, sum8}, lat, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({cout8, sum8} !== exp || in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got %h in_ready=%b out_valid=%b, required %h 0 1",
                 i, {cout8, sum8}, in_ready8, out_valid8, exp);
      end
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready8, out_valid8);
    end
    exp_q.push_back(9'h0BC);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    wait_out8(lat);
    exp = exp_q.pop_front();
    n_checks++;
    if ({cout8, sum8} !== exp || lat != 8) begin
      n_fail++;
      $display("FAIL bp_second: got %h lat %0d, required %h lat 8", {cout8, sum8}, lat, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    logic [8:0] got, exp;
    out_ready8 = 1'b1;
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    n_checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: out_valid=%b in_ready=%b sum=%h cout=%b, required 0 1 00 0",
               out_valid8, in_ready8, sum8, cout8);
    end
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(9'h100);
    op8(8'h80, 8'h80, 1'b0, lat, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || lat != 8) begin
      n_fail++;
      $display("FAIL after_reset_op: got %h lat %0d, required %h lat 8", got, lat, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int unsigned sent = 0, recv = 0, cyc = 0;
    logic [8:0] exp;
    while ((sent < 1000 || exp_q.size() != 0) && cyc < 60000) begin
      in_valid8  = (sent < 1000) && ($urandom_range(3) != 0);
      a8         = 8'($urandom);
      b8         = 8'($urandom);
      cin8       = 1'($urandom_range(1));
      out_ready8 = ($urandom_range(2) != 0);
      @(negedge clk);
      if (in_valid8 && in_ready8) begin
        exp_q.push_back({1'b0, a8} + {1'b0, b8} + {8'h00, cin8});
        sent++;
      end
      if (out_valid8 && out_ready8) begin
        n_checks++;
        recv++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: result %h with empty scoreboard", {cout8, sum8});
        end else begin
          exp = exp_q.pop_front();
          if ({cout8, sum8} !== exp) begin
            n_fail++;
            $display("FAIL stream_result[%0d]: got %h, required %h", recv, {cout8, sum8}, exp);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid8 = 1'b0;
    n_checks++;
    if (sent != 1000 || recv != 1000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: sent %0d received %0d pending %0d, required 1000 1000 0",
               sent, recv, exp_q.size());
    end
  endtask

  task automatic test_width1;
    int lat;
    logic [1:0] exp;
    out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      exp = 2'(a1) + 2'(b1) + 2'(cin1);
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      lat = 0;
      while (out_valid1 !== 1'b1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      n_checks++;
      if ({cout1, sum1} !== exp || lat != 1) begin
        n_fail++;
        $display("FAIL width1[%0d]: got {cout,sum}=%b lat %0d, required %b lat 1",
                 i, {cout1, sum1}, lat, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
